// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register in front of the shifter.
// The holding register lets the next word be queued while the current word is still shifting out.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state,     r_state_next;
    logic             r_hold_full, r_hold_full_next;
    logic [WIDTH-1:0] r_hold_reg,  r_hold_reg_next;
    logic [WIDTH-1:0] r_shift_reg, r_shift_reg_next;
    logic [CW-1:0]    r_cnt,       r_cnt_next;

    logic             w_accept;
    logic             w_last;
    logic             w_out_end;
    logic [WIDTH-1:0] w_shifted;

    // The output end of the shifter depends on bit order; the shift always moves data toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift_reg[WIDTH-2:0], 1'b0};
            assign w_out_end = r_shift_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shift_reg[WIDTH-1:1]};
            assign w_out_end = r_shift_reg[0];
        end
    endgenerate

    assign in_ready  = rstn & ~r_hold_full;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == LAST_IDX);
    assign out_valid = (r_state == SHIFT);
    assign out_bit   = out_valid & w_out_end;
    assign word_done = out_valid & en & w_last;
    assign busy      = out_valid | r_hold_full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_hold_full <= 1'b0;
            r_hold_reg  <= '0;
            r_shift_reg <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= r_state_next;
            r_hold_full <= r_hold_full_next;
            r_hold_reg  <= r_hold_reg_next;
            r_shift_reg <= r_shift_reg_next;
            r_cnt       <= r_cnt_next;
        end
    end

    // Acceptance needs an empty holder and loading needs a full one, so the two never collide.
    always_comb begin
        r_state_next     = r_state;
        r_hold_full_next = r_hold_full;
        r_hold_reg_next  = r_hold_reg;
        r_shift_reg_next = r_shift_reg;
        r_cnt_next       = r_cnt;

        if (w_accept) begin
            r_hold_reg_next  = in_data;
            r_hold_full_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    r_shift_reg_next = r_hold_reg;
                    r_cnt_next       = '0;
                    r_hold_full_next = 1'b0;
                    r_state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (w_last) begin
                        if (r_hold_full) begin
                            r_shift_reg_next = r_hold_reg;
                            r_cnt_next       = '0;
                            r_hold_full_next = 1'b0;
                        end else begin
                            r_state_next = IDLE;
                        end
                    end else begin
                        r_shift_reg_next = w_shifted;
                        r_cnt_next       = r_cnt + CW'(1);
                    end
                end
            end
            default: r_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus, and a bit
// scoreboard filled on acceptance is drained by a negedge monitor.
module tb_bit_serializer;

    logic       clk;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       en;

    logic in_ready_m, out_bit_m, out_valid_m, word_done_m, busy_m;
    logic in_ready_l, out_bit_l, out_valid_l, word_done_l, busy_l;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
        .en(en), .out_bit(out_bit_m), .out_valid(out_valid_m), .word_done(word_done_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .en(en), .out_bit(out_bit_l), .out_valid(out_valid_l), .word_done(word_done_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_m / exp_l: bits in emission order, first emitted bit in [7]
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    typedef struct packed {
        logic bm;
        logic bl;
        logic last;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int run_len   = 0;
    int last_run  = 0;
    int det_count = 0;
    logic [3:0] det_hist = 4'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Called just after a posedge; returns #1 after the accepting edge.
    task automatic send_word(input logic [7:0] data, input logic [7:0] em, input logic [7:0] el,
                             input bit junk);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = junk ? 8'($urandom) : data;
        forever begin
            @(negedge clk);
            if (in_ready_m) break;
            if (junk) in_data = 8'($urandom);
            n++;
            if (n > 200) begin
                fail_now("send_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        in_data = data;
        for (int i = 0; i < 8; i++) q.push_back('{bm: em[7-i], bl: el[7-i], last: (i == 7)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        $display("word %02h accepted", data);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 || out_valid_m) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid_m) begin
            run_len++;
            if (q.size() == 0) begin
                fail_now("unexpected_bit");
            end else begin
                e = q[0];
                check("out_bit_m", out_bit_m, e.bm);
                check("out_bit_l", out_bit_l, e.bl);
                check("out_valid_l", out_valid_l, 1);
                check("word_done_m", word_done_m, en & e.last);
                check("word_done_l", word_done_l, en & e.last);
                if (en) begin
                    void'(q.pop_front());
                    det_hist = {det_hist[2:0], out_bit_m};
                    if (det_hist == 4'b1011) det_count++;
                end
            end
        end else begin
            check("idle_out_bit", out_bit_m, 0);
            check("idle_word_done", word_done_m, 0);
            check("idle_out_valid_l", out_valid_l, 0);
            if (run_len > 0) last_run = run_len;
            run_len  = 0;
            det_hist = 4'b0;
        end
    end

    initial begin
        int d0;
        vecs[0] = '{8'hB5, 8'hB5, 8'hAD};
        vecs[1] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[2] = '{8'hB0, 8'hB0, 8'h0D};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[5] = '{8'h81, 8'h81, 8'h81};
        vecs[6] = '{8'h6E, 8'h6E, 8'h76};
        vecs[7] = '{8'h01, 8'h01, 8'h80};

        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_m, 0);
        check("rst_in_ready_l", in_ready_l, 0);
        check("rst_out_valid", out_valid_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_out_bit", out_bit_m, 0);
        check("rst_word_done", word_done_m, 0);
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready_m, 1);

        // latency and single word
        send_word(8'hB5, 8'hB5, 8'hAD, 1'b0);
        check("lat_k_out_valid", out_valid_m, 0);
        check("lat_k_busy", busy_m, 1);
        check("lat_k_in_ready", in_ready_m, 0);
        @(posedge clk);
        #1;
        check("lat_k1_out_valid", out_valid_m, 1);
        drain();
        check("single_run_len", last_run, 8);

        // back-to-back, no gap
        send_word(8'hB5, 8'hB5, 8'hAD, 1'b0);
        send_word(8'h0F, 8'h0F, 8'hF0, 1'b0);
        check("held_in_ready", in_ready_m, 0);
        check("held_busy", busy_m, 1);
        drain();
        check("b2b_run_len", last_run, 16);

        // en stall on the 2nd bit of B0
        d0 = det_count;
        send_word(8'hB0, 8'hB0, 8'h0D, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        drain();
        check("stall_run_len", last_run, 11);
        check("detect_1011_count", det_count - d0, 1);

        // table-driven stream
        for (int i = 0; i < 8; i++) send_word(vecs[i].data, vecs[i].exp_m, vecs[i].exp_l, 1'b0);
        drain();
        check("table_run_len", last_run, 64);

        // changing in_data while the holder is full
        send_word(8'hB5, 8'hB5, 8'hAD, 1'b0);
        send_word(8'h0F, 8'h0F, 8'hF0, 1'b0);
        send_word(8'h3C, 8'h3C, 8'h3C, 1'b1);
        drain();
        check("junk_run_len", last_run, 24);

        // reset during the 4th bit with a second word held
        send_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
        send_word(8'h3C, 8'h3C, 8'h3C, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", busy_m, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready_m, 0);
        @(posedge clk);
        q.delete();
        #1;
        check("mid_rst_out_valid", out_valid_m, 0);
        check("mid_rst_busy", busy_m, 0);
        check("mid_rst_busy_l", busy_l, 0);
        check("mid_rst_in_ready2", in_ready_m, 0);
        @(posedge clk);
        #1;
        check("mid_rst_in_ready3", in_ready_l, 0);
        rstn = 1'b1;
        #1;
        check("rel_in_ready", in_ready_m, 1);
        check("rel_busy", busy_m, 0);
        repeat (10) @(posedge clk);
        #1;
        check("rel_idle_out_valid", out_valid_m, 0);

        // normal operation after reset
        send_word(8'h6E, 8'h6E, 8'h76, 1'b0);
        drain();
        check("after_rst_run_len", last_run, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
